rabbit_init_ctrl: RTL and testbench

//  Sequencing FSM for the Rabbit core: key setup, optional IV setup, keystream delivery.

---
 rtl/rabbit_init_ctrl.sv | 157 +++++++++++++++
 tb/tb_rabbit_init_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rabbit_init_ctrl.sv
// Sequencing FSM for the Rabbit core: key setup, optional IV setup and keystream
// handshake. Drives one-cycle datapath strobes decoded from the FSM state.
module rabbit_init_ctrl #(
    parameter int KEY_ITERS = 4,
    parameter int IV_ITERS  = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_start_i,
    input  logic             use_iv_i,
    input  logic             iv_start_i,
    input  logic             ks_ready_i,
    output logic             load_key_o,
    output logic             iter_en_o,
    output logic             ctr_fix_o,
    output logic             save_master_o,
    output logic             restore_master_o,
    output logic             load_iv_o,
    output logic             ks_valid_o,
    output logic             busy_o,
    output logic             key_ok_o,
    output logic             err_o,
    output logic [CNT_W-1:0] iter_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_KEY_LOAD = 4'd1,
        S_KEY_ITER = 4'd2,
        S_KEY_FIX  = 4'd3,
        S_SAVE     = 4'd4,
        S_RESTORE  = 4'd5,
        S_IV_LOAD  = 4'd6,
        S_IV_ITER  = 4'd7,
        S_READY    = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_ITERS - 1);
    localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_ITERS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Output bits: 0 load_key, 1 iter, 2 ctr_fix, 3 save, 4 restore, 5 load_iv, 6 ks_valid, 7 busy
    function automatic logic [7:0] decode_outputs(input state_t s);
        logic [7:0] o;
        case (s)
            S_IDLE:     o = 8'b0000_0000;
            S_KEY_LOAD: o = 8'b1000_0001;
            S_KEY_ITER: o = 8'b1000_0010;
            S_KEY_FIX:  o = 8'b1000_0100;
            S_SAVE:     o = 8'b1000_1000;
            S_RESTORE:  o = 8'b1001_0000;
            S_IV_LOAD:  o = 8'b1010_0000;
            S_IV_ITER:  o = 8'b1000_0010;
            S_READY:    o = 8'b0100_0000;
            default:    o = 8'b0000_0000;
        endcase
        return o;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_ok_q, key_ok_d;
    logic             use_iv_q, use_iv_d;
    logic             err_q, err_d;
    logic [7:0]       out_q, out_d;

    // Next-state, iteration counter, command acceptance and rejection
    always_comb begin
        state_d  = state_q;
        cnt_d    = CNT_ZERO;
        key_ok_d = key_ok_q;
        use_iv_d = use_iv_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE, S_READY: begin
                if (key_start_i) begin
                    state_d  = S_KEY_LOAD;
                    use_iv_d = use_iv_i;
                    key_ok_d = 1'b0;
                end else if (iv_start_i) begin
                    if (key_ok_q) begin
                        state_d = S_RESTORE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_KEY_LOAD: state_d = S_KEY_ITER;
            S_KEY_ITER: begin
                if (cnt_q == KEY_LAST) begin
                    state_d = S_KEY_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_KEY_FIX:  state_d = S_SAVE;
            S_SAVE: begin
                key_ok_d = 1'b1;
                state_d  = use_iv_q ? S_IV_LOAD : S_READY;
            end
            S_RESTORE:  state_d = S_IV_LOAD;
            S_IV_LOAD:  state_d = S_IV_ITER;
            S_IV_ITER: begin
                if (cnt_q == IV_LAST) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
        // Commands arriving mid-sequence are flagged but never disturb it
        if (out_q[7] && (key_start_i || iv_start_i)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
        out_d = decode_outputs(state_d);
    end

    // State and registered output decode, synchronous reset aborts any sequence
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            key_ok_q <= 1'b0;
            use_iv_q <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= 8'b0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_ok_q <= key_ok_d;
            use_iv_q <= use_iv_d;
            err_q    <= err_d;
            out_q    <= out_d;
        end
    end

    assign load_key_o       = out_q[0];
    // In READY one keystream block advances per accepted handshake
    assign iter_en_o        = out_q[1] | (out_q[6] & ks_ready_i);
    assign ctr_fix_o        = out_q[2];
    assign save_master_o    = out_q[3];
    assign restore_master_o = out_q[4];
    assign load_iv_o        = out_q[5];
    assign ks_valid_o       = out_q[6];
    assign busy_o           = out_q[7];
    assign key_ok_o         = key_ok_q;
    assign err_o            = err_q;
    assign iter_cnt_o       = cnt_q;

endmodule

// File: tb/tb_rabbit_init_ctrl.sv
// Bench for rabbit_init_ctrl: directed vector table, hand-written corner sequences,
// and random stimulus checked against a schedule-queue model.
module tb_rabbit_init_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, ks = 1'b0, uiv = 1'b0, ivs = 1'b0, rdy = 1'b0;
    logic load_key, iter_en, ctr_fix, save_master, restore_master, load_iv;
    logic ks_valid, busy, key_ok, err;
    logic [2:0] iter_cnt;

    rabbit_init_ctrl #(.KEY_ITERS(4), .IV_ITERS(4), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .key_start_i(ks), .use_iv_i(uiv), .iv_start_i(ivs),
        .ks_ready_i(rdy), .load_key_o(load_key), .iter_en_o(iter_en), .ctr_fix_o(ctr_fix),
        .save_master_o(save_master), .restore_master_o(restore_master), .load_iv_o(load_iv),
        .ks_valid_o(ks_valid), .busy_o(busy), .key_ok_o(key_ok), .err_o(err),
        .iter_cnt_o(iter_cnt)
    );

    localparam int C_N = 0, C_L = 1, C_I = 2, C_F = 3, C_S = 4, C_R = 5, C_V = 6, C_MULTI = 7;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic r, k, u, i, y;
        int   code;
        logic v, b, kk, e;
        int   cnt;
    } vec_t;
    vec_t tbl[$];

    // Model: queue of per-cycle (strobe, count) entries still to be emitted
    typedef struct { int code; int cnt; } ent_t;
    ent_t q[$];
    bit m_ready = 1'b0, m_kok = 1'b0, m_err = 1'b0;

    function automatic int obs_code();
        int n;
        n = int'(load_key) + int'(iter_en) + int'(ctr_fix) + int'(save_master)
            + int'(restore_master) + int'(load_iv);
        if (n > 1) return C_MULTI;
        if (load_key) return C_L;
        if (iter_en) return C_I;
        if (ctr_fix) return C_F;
        if (save_master) return C_S;
        if (restore_master) return C_R;
        if (load_iv) return C_V;
        return C_N;
    endfunction

    function automatic logic [11:0] pack(int code, logic v, logic b, logic k, logic e, int cnt);
        return {4'(code), v, b, k, e, 4'(cnt)};
    endfunction

    task automatic check(string name, logic [11:0] exp);
        logic [11:0] act;
        act = pack(obs_code(), ks_valid, busy, key_ok, err, int'(iter_cnt));
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got code/v/b/k/e/cnt=%h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic k, logic u, logic i, logic y);
        @(negedge clk);
        rst = r; ks = k; uiv = u; ivs = i; rdy = y;
        #1;
    endtask

    task automatic push_iter(int n);
        for (int c = 0; c < n; c++) q.push_back('{C_I, c});
    endtask

    task automatic push_iv();
        q.push_back('{C_V, 0});
        push_iter(4);
    endtask

    // Advance the model across one clock edge using the currently driven inputs
    task automatic model_step();
        bit e;
        e = 1'b0;
        if (rst) begin
            q.delete();
            m_ready = 1'b0;
            m_kok = 1'b0;
        end else if (q.size() > 0) begin
            if (ks || ivs) e = 1'b1;
            if (q[0].code == C_S) m_kok = 1'b1;
            void'(q.pop_front());
            if (q.size() == 0) m_ready = 1'b1;
        end else if (ks) begin
            m_kok = 1'b0;
            q.push_back('{C_L, 0});
            push_iter(4);
            q.push_back('{C_F, 0});
            q.push_back('{C_S, 0});
            if (uiv) push_iv();
        end else if (ivs) begin
            if (m_kok) begin
                q.push_back('{C_R, 0});
                push_iv();
            end else begin
                e = 1'b1;
            end
        end
        m_err = e;
    endtask

    function automatic logic [11:0] model_exp();
        if (q.size() > 0) return pack(q[0].code, 1'b0, 1'b1, m_kok, m_err, q[0].cnt);
        return pack((m_ready && rdy) ? C_I : C_N, m_ready, 1'b0, m_kok, m_err, 0);
    endfunction

    task automatic add(logic r, logic k, logic u, logic i, logic y,
                       int code, logic v, logic b, logic kk, logic e, int cnt);
        tbl.push_back('{r, k, u, i, y, code, v, b, kk, e, cnt});
    endtask

    initial begin
        // Key setup without IV, then READY handshake toggling
        add(0,1,0,0,0, C_N,0,0,0,0,0);
        add(0,0,0,0,0, C_L,0,1,0,0,0);
        for (int c = 0; c < 4; c++) add(0,0,0,0,0, C_I,0,1,0,0,c);
        add(0,0,0,0,0, C_F,0,1,0,0,0);
        add(0,0,0,0,0, C_S,0,1,0,0,0);
        add(0,0,0,0,0, C_N,1,0,1,0,0);
        add(0,0,0,0,1, C_I,1,0,1,0,0);
        add(0,0,0,0,0, C_N,1,0,1,0,0);
        add(0,0,0,0,1, C_I,1,0,1,0,0);
        add(0,0,0,0,1, C_I,1,0,1,0,0);
        // Re-IV from READY
        add(0,0,0,1,0, C_N,1,0,1,0,0);
        add(0,0,0,0,0, C_R,0,1,1,0,0);
        add(0,0,0,0,0, C_V,0,1,1,0,0);
        for (int c = 0; c < 4; c++) add(0,0,0,0,0, C_I,0,1,1,0,c);
        add(0,0,0,0,0, C_N,1,0,1,0,0);
        // key_start beats iv_start; a command while busy pulses err only
        add(0,1,0,1,0, C_N,1,0,1,0,0);
        add(0,0,0,0,0, C_L,0,1,0,0,0);
        add(0,0,0,0,0, C_I,0,1,0,0,0);
        add(0,0,0,1,0, C_I,0,1,0,0,1);
        add(0,0,0,0,0, C_I,0,1,0,1,2);
        add(0,0,0,0,0, C_I,0,1,0,0,3);
        add(0,0,0,0,0, C_F,0,1,0,0,0);
        add(0,0,0,0,0, C_S,0,1,0,0,0);
        add(0,0,0,0,0, C_N,1,0,1,0,0);
        // Key setup followed by IV setup
        add(0,1,1,0,0, C_N,1,0,1,0,0);
        add(0,0,0,0,0, C_L,0,1,0,0,0);
        for (int c = 0; c < 4; c++) add(0,0,0,0,0, C_I,0,1,0,0,c);
        add(0,0,0,0,0, C_F,0,1,0,0,0);
        add(0,0,0,0,0, C_S,0,1,0,0,0);
        add(0,0,0,0,0, C_V,0,1,1,0,0);
        for (int c = 0; c < 4; c++) add(0,0,0,0,0, C_I,0,1,1,0,c);
        add(0,0,0,0,0, C_N,1,0,1,0,0);

        drive(1,0,0,0,0); model_step();
        drive(1,0,0,0,0); model_step();
        drive(0,0,0,0,0);
        check("reset_state", pack(C_N,0,0,0,0,0));
        model_step();

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].r, tbl[n].k, tbl[n].u, tbl[n].i, tbl[n].y);
            check($sformatf("vec%0d", n),
                  pack(tbl[n].code, tbl[n].v, tbl[n].b, tbl[n].kk, tbl[n].e, tbl[n].cnt));
            model_step();
        end

        // iv_start without a master key is rejected and stays IDLE
        drive(1,0,0,0,0); model_step();
        drive(0,0,0,1,0);
        check("nokey_idle", pack(C_N,0,0,0,0,0)); model_step();
        drive(0,0,0,0,0);
        check("nokey_err", pack(C_N,0,0,0,1,0)); model_step();
        drive(0,0,0,0,0);
        check("nokey_err_clear", pack(C_N,0,0,0,0,0)); model_step();

        // Reset in the middle of KEY_ITER aborts the sequence
        drive(0,1,0,0,0);
        check("abort_cmd", pack(C_N,0,0,0,0,0)); model_step();
        drive(0,0,0,0,0);
        check("abort_load", pack(C_L,0,1,0,0,0)); model_step();
        drive(0,0,0,0,0);
        check("abort_it0", pack(C_I,0,1,0,0,0)); model_step();
        drive(0,0,0,0,0);
        check("abort_it1", pack(C_I,0,1,0,0,1)); model_step();
        drive(1,0,0,0,0);
        check("abort_it2", pack(C_I,0,1,0,0,2)); model_step();
        drive(0,0,0,0,0);
        check("abort_reset", pack(C_N,0,0,0,0,0)); model_step();

        // Random stimulus against the model
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)));
            check($sformatf("rand%0d", n), model_exp());
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
